imem_ctrl: RTL



---
 rtl/imem_ctrl_if.sv | 45 ++++
 rtl/imem_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/imem_ctrl_if.sv
// ============================================================================
// imem_ctrl_if : host loader, fetch unit and memory port signals of imem_ctrl
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int PC_WIDTH   = 12
) ();
    logic                    host_vld;
    logic                    host_rdy;
    logic [DATA_WIDTH/4-1:0] host_wdata;
    logic                    host_last;
    logic [PC_WIDTH-1:0]     host_start_addr;
    logic                    host_reload;
    logic                    ifu_mem_ce;
    logic [ADDR_WIDTH-1:0]   ifu_mem_addr;
    logic                    ifu_mem_gnt;
    logic                    mem_ce;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_din;
    logic                    start_vld;
    logic [PC_WIDTH-1:0]     start_addr;
    logic                    busy;
    logic                    ovf;

    modport slave (
        input  host_vld, host_wdata, host_last, host_start_addr, host_reload,
        input  ifu_mem_ce, ifu_mem_addr,
        output host_rdy, ifu_mem_gnt, mem_ce, mem_we, mem_addr, mem_din,
        output start_vld, start_addr, busy, ovf
    );

    modport master (
        output host_vld, host_wdata, host_last, host_start_addr, host_reload,
        output ifu_mem_ce, ifu_mem_addr,
        input  host_rdy, ifu_mem_gnt, mem_ce, mem_we, mem_addr, mem_din,
        input  start_vld, start_addr, busy, ovf
    );
endinterface

`default_nettype wire

// File: rtl/imem_ctrl.sv
// ============================================================================
// imem_ctrl : packs host words into instruction memory lines, then hands the
//             single memory port to the fetch unit until a reload request.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int PC_WIDTH   = 12
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    imem_ctrl_if.slave  bus
);
    localparam int c_WORD_W = DATA_WIDTH / 4;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_WRITE = 3'd2;
    localparam logic [2:0] c_START = 3'd3;
    localparam logic [2:0] c_RUN   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_LINE_ONE = 1;
    localparam logic [PC_WIDTH-1:0]   c_PC_ALIGN = ~(PC_WIDTH'(3));

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_line_ptr;
    logic [1:0]            r_slot;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_last;
    logic                  r_ovf;

    logic                  w_host_rdy;
    logic                  w_accept;
    logic                  w_line_done;
    logic                  w_fetch_owns;

    assign w_host_rdy   = (r_state == c_IDLE) || (r_state == c_FILL);
    assign w_accept     = bus.host_vld & w_host_rdy;
    assign w_line_done  = w_accept & ((r_slot == 2'd3) | bus.host_last);
    assign w_fetch_owns = (r_state == c_START) || (r_state == c_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_line_ptr <= '0;
            r_slot     <= 2'd0;
            r_buf      <= '0;
            r_pc       <= '0;
            r_last     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_FILL: begin
                    if (w_accept) begin
                        r_buf[r_slot*c_WORD_W +: c_WORD_W] <= bus.host_wdata;
                        r_slot  <= r_slot + 2'd1;
                        r_state <= w_line_done ? c_WRITE : c_FILL;
                        if (bus.host_last) begin
                            r_last <= 1'b1;
                            r_pc   <= bus.host_start_addr;
                        end
                    end
                end
                c_WRITE: begin
                    r_line_ptr <= r_line_ptr + c_LINE_ONE;
                    r_slot     <= 2'd0;
                    r_buf      <= '0;
                    if (r_last) begin
                        r_last  <= 1'b0;
                        r_state <= c_START;
                    end else begin
                        // Wrapping past the top line with words still to come.
                        if (&r_line_ptr) r_ovf <= 1'b1;
                        r_state <= c_FILL;
                    end
                end
                c_START: r_state <= c_RUN;
                c_RUN: begin
                    if (bus.host_reload) begin
                        r_state    <= c_IDLE;
                        r_line_ptr <= '0;
                        r_ovf      <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_ce      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_din     = '0;
        bus.ifu_mem_gnt = 1'b0;
        if (r_state == c_WRITE) begin
            bus.mem_ce   = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = r_line_ptr;
            bus.mem_din  = r_buf;
        end else if (w_fetch_owns) begin
            bus.mem_ce      = bus.ifu_mem_ce;
            bus.mem_addr    = bus.ifu_mem_addr;
            bus.ifu_mem_gnt = bus.ifu_mem_ce;
        end
    end

    assign bus.host_rdy   = w_host_rdy;
    assign bus.start_vld  = (r_state == c_START);
    assign bus.start_addr = (r_state == c_START) ? (r_pc & c_PC_ALIGN) : '0;
    assign bus.busy       = (r_state == c_FILL) || (r_state == c_WRITE) ||
                            (r_state == c_START);
    assign bus.ovf        = r_ovf;

endmodule

`default_nettype wire
